// File: rtl/rgb_sram_writer.sv
// YUV pixel-pair to RGB converter that packs each pair into three 16-bit words
// and writes them consecutively into the RGB segment of external SRAM.
module rgb_sram_writer #(
  parameter logic [17:0] RGB_BASE  = 18'd146944,
  parameter int          NUM_PAIRS = 38400
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Y0,
  input  logic [7:0]  U0,
  input  logic [7:0]  V0,
  input  logic [7:0]  Y1,
  input  logic [7:0]  U1,
  input  logic [7:0]  V1,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam int              CW        = $clog2(NUM_PAIRS + 1);
  localparam logic [CW-1:0]   PAIRS_MAX = CW'(NUM_PAIRS);
  localparam logic [17:0]     LAST_ADDR = RGB_BASE + 18'(3 * NUM_PAIRS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cooldown_q;
  logic [CW-1:0]   accepted_q;
  logic [17:0]     ptr_q;
  logic            s1_valid_q, s2_valid_q;
  logic [47:0]     px_q;
  logic [23:0]     rgb0_q, rgb1_q;
  logic [1:0]      seq_q;
  logic            xfer;
  logic            writing;

  // Handshake: a pair moves when in_valid and in_ready are both high at a rising
  // edge; in_ready never depends on in_valid and in_valid is ignored when not ready.
  assign xfer      = in_valid & in_ready;
  assign writing   = s2_valid_q | (seq_q != 2'd0);
  assign state_dbg = state_q;

  function automatic logic [7:0] clip(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    if (s < 0)               clip = 8'd0;
    else if (s > 32'sd255)   clip = 8'hFF;
    else                     clip = s[7:0];
  endfunction

  function automatic logic [23:0] to_rgb(input logic [7:0] yy, input logic [7:0] uu,
                                         input logic [7:0] vv);
    logic signed [31:0] y, u, v;
    y = $signed({24'd0, yy}) - 32'sd16;
    u = $signed({24'd0, uu}) - 32'sd128;
    v = $signed({24'd0, vv}) - 32'sd128;
    to_rgb = {clip(32'sd76284 * y + 32'sd104595 * v),
              clip(32'sd76284 * y - 32'sd25624 * u - 32'sd53281 * v),
              clip(32'sd76284 * y + 32'sd132251 * u)};
  endfunction

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_ACTIVE;
      S_ACTIVE: begin
        in_ready = (cooldown_q == 2'd0) && (accepted_q < PAIRS_MAX);
        // The write pointer only moves forward, so seeing the final address on the bus
        // means word2 of the last pair is being written this cycle.
        if (!SRAM_we_n && (SRAM_address == LAST_ADDR)) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      cooldown_q      <= 2'd0;
      accepted_q      <= '0;
      ptr_q           <= '0;
      s1_valid_q      <= 1'b0;
      s2_valid_q      <= 1'b0;
      px_q            <= '0;
      rgb0_q          <= '0;
      rgb1_q          <= '0;
      seq_q           <= 2'd0;
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
    end else begin
      // Stage 1 captures the pair, stage 2 holds clipped RGB for both pixels.
      s1_valid_q <= xfer;
      if (xfer) px_q <= {Y0, U0, V0, Y1, U1, V1};
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rgb0_q <= to_rgb(px_q[47:40], px_q[39:32], px_q[31:24]);
        rgb1_q <= to_rgb(px_q[23:16], px_q[15:8], px_q[7:0]);
      end

      if (state_q == S_IDLE) begin
        cooldown_q <= 2'd0;
        accepted_q <= '0;
        ptr_q      <= RGB_BASE;
      end else begin
        if (xfer) begin
          cooldown_q <= 2'd2;
          accepted_q <= accepted_q + 1'b1;
        end else if (cooldown_q != 2'd0) begin
          cooldown_q <= cooldown_q - 2'd1;
        end
        if (writing) ptr_q <= ptr_q + 18'd1;
      end

      // The 3-cycle accept spacing guarantees the word sequence never overlaps.
      SRAM_we_n <= 1'b1;
      if (s2_valid_q) begin
        SRAM_we_n       <= 1'b0;
        SRAM_address    <= ptr_q;
        SRAM_write_data <= {rgb0_q[23:16], rgb0_q[15:8]};
        seq_q           <= 2'd1;
      end else if (seq_q == 2'd1) begin
        SRAM_we_n       <= 1'b0;
        SRAM_address    <= ptr_q;
        SRAM_write_data <= {rgb0_q[7:0], rgb1_q[23:16]};
        seq_q           <= 2'd2;
      end else if (seq_q == 2'd2) begin
        SRAM_we_n       <= 1'b0;
        SRAM_address    <= ptr_q;
        SRAM_write_data <= {rgb1_q[15:8], rgb1_q[7:0]};
        seq_q           <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Bench for rgb_sram_writer: a cycle-level behavioural model predicts in_ready, done
// and every SRAM bus cycle; a single negedge process compares the DUT against it.
module tb_rgb_sram_writer;

  localparam logic [17:0] RGB_BASE = 18'd146944;
  localparam int          N        = 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] px;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        done;
  logic [1:0]  state_dbg;

  rgb_sram_writer #(.RGB_BASE(RGB_BASE), .NUM_PAIRS(N)) dut (
    .CLOCK_50_I      (clk),
    .Reset           (Reset),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .Y0              (px[47:40]),
    .U0              (px[39:32]),
    .V0              (px[31:24]),
    .Y1              (px[23:16]),
    .U1              (px[15:8]),
    .V1              (px[7:0]),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .done            (done),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef enum {M_IDLE, M_ACTIVE, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  int          m_acc = 0;
  int          m_n = 0;
  int          last_xfer = -1000;
  logic [17:0] held_addr = '0;
  logic [15:0] held_data = '0;
  // entry = {cycle[31:0], address[17:0], data[15:0]}
  logic [65:0] exp_q[$];

  int          xfer_cnt = 0;
  int          frame_wr = 0;
  logic [17:0] first_addr = '0;
  logic [17:0] last_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] clip8(input int a);
    int s;
    s = a >>> 16;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return s[7:0];
  endfunction

  function automatic logic [23:0] pix_rgb(input int yy, input int uu, input int vv);
    int y, u, v;
    y = yy - 16;
    u = uu - 128;
    v = vv - 128;
    return {clip8(76284 * y + 104595 * v),
            clip8(76284 * y - 25624 * u - 53281 * v),
            clip8(76284 * y + 132251 * u)};
  endfunction

  function automatic logic [47:0] pair_words(input logic [47:0] p);
    logic [23:0] a, b;
    a = pix_rgb(int'(p[47:40]), int'(p[39:32]), int'(p[31:24]));
    b = pix_rgb(int'(p[23:16]), int'(p[15:8]), int'(p[7:0]));
    return {a[23:16], a[15:8], a[7:0], b[23:16], b[15:8], b[7:0]};
  endfunction

  function automatic logic [47:0] rand_px();
    logic [47:0] r;
    r = {16'($urandom), 32'($urandom)};
    return r;
  endfunction

  // ---------------- model + compare, every cycle ----------------
  always @(negedge clk) begin
    bit          m_ready;
    bit          wr_now;
    logic [65:0] e;
    logic [47:0] w;
    logic [17:0] a;
    cyc++;
    if (Reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we_n", SRAM_we_n, 1);
      chk("rst_address", SRAM_address, 0);
      chk("rst_data", SRAM_write_data, 0);
      chk("rst_done", done, 0);
      m_state = M_IDLE;
      exp_q.delete();
      held_addr = '0;
      held_data = '0;
    end else begin
      m_ready = (m_state == M_ACTIVE) && (cyc - last_xfer >= 3) && (m_acc < N);
      chk("in_ready", in_ready, m_ready);
      chk("done", done, m_state == M_DONE);
      wr_now = 1'b0;
      if (exp_q.size() > 0 && exp_q[0][65:34] == 32'(cyc)) begin
        e = exp_q.pop_front();
        held_addr = e[33:16];
        held_data = e[15:0];
        wr_now = 1'b1;
      end
      chk("we_n", SRAM_we_n, !wr_now);
      chk("address", SRAM_address, held_addr);
      chk("write_data", SRAM_write_data, held_data);
      if (!SRAM_we_n) begin
        if (frame_wr == 0) first_addr = SRAM_address;
        last_addr = SRAM_address;
        frame_wr++;
      end
      if (in_valid && in_ready) xfer_cnt++;
      case (m_state)
        M_IDLE: if (start) begin
          m_state = M_ACTIVE;
          m_acc = 0;
          m_n = 0;
          last_xfer = -1000;
        end
        M_ACTIVE: begin
          if (m_ready && in_valid) begin
            w = pair_words(px);
            a = RGB_BASE + 18'(3 * m_n);
            exp_q.push_back({32'(cyc + 3), a, w[47:32]});
            exp_q.push_back({32'(cyc + 4), a + 18'd1, w[31:16]});
            exp_q.push_back({32'(cyc + 5), a + 18'd2, w[15:0]});
            m_acc++;
            m_n++;
            last_xfer = cyc;
          end
          if (wr_now && held_addr == RGB_BASE + 18'(3 * N - 1)) m_state = M_DONE;
        end
        M_DONE: if (!start) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      px = rand_px();
    end
  endtask

  task automatic begin_frame();
    xfer_cnt = 0;
    frame_wr = 0;
    start = 1'b1;
  endtask

  task automatic send_pair(input logic [47:0] p);
    bit got;
    got = 1'b0;
    px = p;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_pair_accepted", got, 1);
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_bound", seen, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_pairs_accepted"}, xfer_cnt, N);
    chk({tag, "_words_written"}, frame_wr, 3 * N);
    chk({tag, "_first_addr"}, first_addr, RGB_BASE);
    chk({tag, "_last_addr"}, last_addr, RGB_BASE + 18'd11);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    px = '0;
    #1 Reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    idle(20);

    // Hand-computed words pin the reference arithmetic.
    chk("pin_black_white", pair_words({8'd16, 8'd128, 8'd128, 8'd255, 8'd128, 8'd255}),
        48'h0000_00FF_AEFF);
    chk("pin_negclip_mid", pair_words({8'd0, 8'd0, 8'd128, 8'd235, 8'd128, 8'd128}),
        48'h001F_00FE_FEFE);
    chk("pin_saturate", pair_words({8'd255, 8'd255, 8'd255, 8'd16, 8'd255, 8'd0}),
        48'hFF7D_FF00_36FF);

    // Frame A: directed arithmetic vectors, then random pairs with gaps.
    begin_frame();
    send_pair({8'd16, 8'd128, 8'd128, 8'd255, 8'd128, 8'd255});
    send_pair({8'd0, 8'd0, 8'd128, 8'd235, 8'd128, 8'd128});
    idle($urandom_range(1, 5));
    send_pair({8'd255, 8'd255, 8'd255, 8'd16, 8'd255, 8'd0});
    idle($urandom_range(1, 5));
    send_pair(rand_px());
    wait_done(100);
    check_frame("frameA");
    idle(5);
    start = 1'b0;
    idle(3);

    // Frame B: in_valid held high with changing data; only N pairs may be taken.
    begin_frame();
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      px = rand_px();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_done(60);
    check_frame("frameB");
    idle(4);
    start = 1'b0;
    idle(3);

    // Frame C: start dropped mid-frame is ignored; random gaps between pairs.
    begin_frame();
    send_pair(rand_px());
    start = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      idle($urandom_range(1, 5));
      send_pair(rand_px());
    end
    wait_done(100);
    check_frame("frameC");
    idle(3);

    // Frame D: Reset between word0 and word1 of the third pair, then restart.
    begin_frame();
    send_pair(rand_px());
    send_pair(rand_px());
    send_pair(rand_px());
    @(posedge clk);
    @(posedge clk);
    #7;
    Reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 Reset = 1'b0;
    idle(5);
    chk("reset_words_before_abort", frame_wr, 7);
    begin_frame();
    for (int i = 0; i < N; i++) begin
      send_pair(rand_px());
      idle($urandom_range(0, 3));
    end
    wait_done(100);
    check_frame("frameD");
    start = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
